key_input_ctrl: RTL and testbench
=================================

Name: key_input_ctrl

Overview:
- Producer side of the game_control key interface.
- Converts debounced key-held levels from the keyboard decoder into the single-cycle key pulses game_control consumes.
- Left/right get delayed auto-shift (DAS) plus auto-repeat (ARR); down gets soft-drop repeat; rotate/drop/hold are edge-only.
- Also drives the key_drop_held level.

Parameters:
- DAS_TICKS, 10, ticks a left/right key must be held after its press pulse before the first repeat pulse
- ARR_TICKS, 3, ticks between successive left/right repeat pulses
- SOFT_TICKS, 2, ticks between successive key_down pulses while down is held
- CNT_W, 8, width of the tick counters; all *_TICKS are in 1..2^CNT_W-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  single-cycle timing strobe; all counters advance only on cycles with tick=1
- enable  in  1  0 = input ignored (game over / pause)
- held_left, held_right, held_down, held_rotate, held_drop, held_hold  in  1 each  debounced key-held levels
- key_left, key_right, key_down, key_rotate, key_drop, key_hold  out  1 each  single-cycle action pulses to game_control
- key_drop_held  out  1  registered copy of held_drop, gated by enable

Behaviour:
- All outputs are registered. On rst: every output is 0, the horizontal FSM is IDLE, counters are 0, and the previous-sample registers are 0.
- Edge detection: a press is a cycle where held_X=1 and the registered previous sample prev_X=0. The pulse is asserted for exactly one cycle, in the cycle after the press is sampled (latency 1).
- rotate, drop, hold: one pulse per press, never repeated.
- key_drop_held equals held_drop delayed one cycle.
- Down:
  - Pulse on press; soft counter cleared.
  - While held, the counter increments on tick. When a tick brings it to SOFT_TICKS, pulse key_down and clear the counter.
  - On release, clear the counter.
- Horizontal FSM, shared by left/right. States: IDLE, DAS, REPEAT. Register dir (L/R).
  - IDLE: on a left or right press, pulse that direction, set dir, clear counter, go to DAS. If both are pressed in the same cycle, left wins.
  - DAS: on tick, increment the counter. When it reaches DAS_TICKS, pulse dir, clear the counter, go to REPEAT.
  - REPEAT: on tick, increment the counter. When it reaches ARR_TICKS, pulse dir and clear the counter.
  - Opposite-direction press while in DAS or REPEAT (last-pressed wins): pulse the new direction, set dir, clear the counter, go to DAS.
  - Active direction released while the other is still held: switch dir, pulse it as a fresh press, clear the counter, go to DAS.
  - Active direction released with no other held: go to IDLE, clear the counter.
- Press and tick in the same cycle: the press takes priority; the counter is cleared, not incremented.
- At most one pulse per output per cycle. key_left and key_right are never both 1.
- enable=0:
  - All pulse outputs and key_drop_held are forced to 0; FSM goes to IDLE; counters are cleared.
  - prev_X keeps tracking held_X, so a key already held when enable rises produces no pulse until it is released and re-pressed.
- Reset mid-hold: state clears. A key still held after reset does not pulse until it is re-pressed, because prev_X is only released to normal tracking after the first post-reset cycle.
- Counters saturate at 2^CNT_W-1; they never wrap.

Optional Feature:
- Macro: INPUT_AUTOREPEAT_EN.
- Defined: DAS/ARR and soft-drop repeat behave as specified above.
- Undefined:
  - left, right and down are edge-only (one pulse per press).
  - The horizontal FSM reduces to IDLE plus dir tracking; the counters and the DAS_TICKS/ARR_TICKS/SOFT_TICKS logic are not synthesized.
  - The last-pressed-wins and release-switch rules still apply, each producing a single pulse.

Test Plan:
- Reset with held_rotate=1, then release rst and hold 20 cycles → no key_rotate pulse. Release, then press → exactly one key_rotate pulse, 1 cycle after the press is sampled.
- Repeat timing (DAS_TICKS=4, ARR_TICKS=2, tick every 10 cycles), hold held_left for 100 cycles → key_left pulses at press+1, then on the 4th tick, then every 2nd tick. Exactly 5 pulses total (ticks 4, 6, 8, 10) and key_right stays 0.
- Last-pressed wins: hold right, press left on tick 2 → left pulse, then DAS restarts. Release left with right still held → immediate right pulse, then DAS restarts for right.
- Simultaneous left+right press from IDLE → key_left only.
- Soft drop (SOFT_TICKS=2), hold down for 6 ticks → 4 key_down pulses: 1 on press, then on ticks 2, 4, 6.
- Enable gating: drop enable during REPEAT → no pulses, key_drop_held=0. Raise enable with left still held → no pulse until left is released and re-pressed.
- With INPUT_AUTOREPEAT_EN undefined, repeat the 100-cycle left hold → exactly 1 key_left pulse.

Source files
------------

// File: rtl/key_input_ctrl.sv
// ---------------------------------------------------------------------------
// key_input_ctrl
//
// Producer side of the game_control key interface. Turns debounced key-held
// levels from the keyboard decoder into the single-cycle action pulses that
// game_control consumes.
//   * left/right : shared horizontal FSM with delayed auto-shift (DAS) and
//                  auto-repeat (ARR); last-pressed direction wins.
//   * down       : pulse on press, then soft-drop repeat every SOFT_TICKS.
//   * rotate/drop/hold : one pulse per press.
//   * key_drop_held    : held_drop delayed one cycle, gated by enable.
//
// Build option: INPUT_AUTOREPEAT_EN
//   defined   - DAS/ARR and soft-drop repeat are built in.
//   undefined - left/right/down are edge-only; the tick counters and the
//               *_TICKS comparison logic are not built. Direction tracking,
//               last-pressed-wins and release-switch still apply.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   tick          in   timing strobe; counters advance only when tick=1
//   enable        in   0 = input ignored (game over / pause)
//   held_*        in   debounced key-held levels (left, right, down,
//                      rotate, drop, hold)
//   key_*         out  single-cycle registered action pulses
//   key_drop_held out  registered held_drop, gated by enable
// ---------------------------------------------------------------------------
module key_input_ctrl #(
  parameter int DAS_TICKS  = 10,
  parameter int ARR_TICKS  = 3,
  parameter int SOFT_TICKS = 2,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic enable,
  input  logic held_left,
  input  logic held_right,
  input  logic held_down,
  input  logic held_rotate,
  input  logic held_drop,
  input  logic held_hold,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held
);

  // Bit positions of each key inside the packed held/prev/press vectors.
  localparam int K_LEFT   = 0;
  localparam int K_RIGHT  = 1;
  localparam int K_DOWN   = 2;
  localparam int K_ROTATE = 3;
  localparam int K_DROP   = 4;
  localparam int K_HOLD   = 5;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_DAS    = 2'd1,
    H_REPEAT = 2'd2
  } hstate_e;

  // Direction encoding for dir_q.
  localparam logic DIR_L = 1'b0;

  logic [5:0] held_w;
  logic [5:0] prev_q;
  logic [5:0] press_w;
  logic       armed_q;

  hstate_e    hstate_q;
  logic       dir_q;

  logic       key_left_q;
  logic       key_right_q;
  logic       key_down_q;
  logic       key_rotate_q;
  logic       key_drop_q;
  logic       key_hold_q;
  logic       key_drop_held_q;

  logic       act_held_w;
  logic       oth_held_w;
  logic       oth_press_w;

  assign held_w = {held_hold, held_drop, held_rotate,
                   held_down, held_right, held_left};

  // armed_q stays low for the first cycle after reset so that a key held
  // through reset is absorbed into prev_q instead of being seen as a press.
  assign press_w = held_w & ~prev_q & {6{armed_q}};

  // Active / other direction views relative to the current dir_q.
  assign act_held_w  = (dir_q == DIR_L) ? held_left       : held_right;
  assign oth_held_w  = (dir_q == DIR_L) ? held_right      : held_left;
  assign oth_press_w = (dir_q == DIR_L) ? press_w[K_RIGHT] : press_w[K_LEFT];

`ifdef INPUT_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DAS_C  = CNT_W'(DAS_TICKS);
  localparam logic [CNT_W-1:0] ARR_C  = CNT_W'(ARR_TICKS);
  localparam logic [CNT_W-1:0] SOFT_C = CNT_W'(SOFT_TICKS);

  logic [CNT_W-1:0] hcnt_q;
  logic [CNT_W-1:0] scnt_q;
  logic [CNT_W-1:0] hcnt_inc_w;
  logic [CNT_W-1:0] scnt_inc_w;
  logic [CNT_W-1:0] hlimit_w;

  // Counters stop at all-ones rather than wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hcnt_inc_w = sat_inc(hcnt_q);
  assign scnt_inc_w = sat_inc(scnt_q);
  assign hlimit_w   = (hstate_q == H_DAS) ? DAS_C : ARR_C;
`else
  // Timing inputs have no effect in the edge-only build.
  logic unused_cfg;
  assign unused_cfg = tick ^ ((DAS_TICKS + ARR_TICKS + SOFT_TICKS + CNT_W) > 0);
`endif

  // -------------------------------------------------------------------------
  // Edge detection and edge-only keys
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q          <= '0;
      armed_q         <= 1'b0;
      key_rotate_q    <= 1'b0;
      key_drop_q      <= 1'b0;
      key_hold_q      <= 1'b0;
      key_drop_held_q <= 1'b0;
    end else begin
      // prev_q tracks the keys even while disabled, so a key already down
      // when enable rises never counts as a press.
      prev_q          <= held_w;
      armed_q         <= 1'b1;
      key_rotate_q    <= enable & press_w[K_ROTATE];
      key_drop_q      <= enable & press_w[K_DROP];
      key_hold_q      <= enable & press_w[K_HOLD];
      key_drop_held_q <= enable & held_drop;
    end
  end

  // -------------------------------------------------------------------------
  // Down key: pulse on press, soft-drop repeat while held
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      key_down_q <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
      scnt_q     <= '0;
`endif
    end else begin
      key_down_q <= 1'b0;
      if (!enable) begin
`ifdef INPUT_AUTOREPEAT_EN
        scnt_q <= '0;
`endif
      end else if (press_w[K_DOWN]) begin
        key_down_q <= 1'b1;
`ifdef INPUT_AUTOREPEAT_EN
        scnt_q     <= '0;
      end else if (!held_down) begin
        scnt_q <= '0;
      end else if (tick) begin
        if (scnt_inc_w == SOFT_C) begin
          key_down_q <= 1'b1;
          scnt_q     <= '0;
        end else begin
          scnt_q <= scnt_inc_w;
        end
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Horizontal FSM (left/right share one state machine and one counter)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      hstate_q    <= H_IDLE;
      dir_q       <= DIR_L;
      key_left_q  <= 1'b0;
      key_right_q <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
      hcnt_q      <= '0;
`endif
    end else begin
      key_left_q  <= 1'b0;
      key_right_q <= 1'b0;
      if (!enable) begin
        hstate_q <= H_IDLE;
`ifdef INPUT_AUTOREPEAT_EN
        hcnt_q   <= '0;
`endif
      end else begin
        case (hstate_q)
          H_IDLE: begin
            // Left wins a simultaneous left+right press.
            if (press_w[K_LEFT] || press_w[K_RIGHT]) begin
              dir_q       <= ~press_w[K_LEFT];
              key_left_q  <= press_w[K_LEFT];
              key_right_q <= ~press_w[K_LEFT];
              hstate_q    <= H_DAS;
`ifdef INPUT_AUTOREPEAT_EN
              hcnt_q      <= '0;
`endif
            end
          end
          default: begin
            // Switch direction either when the opposite key is freshly
            // pressed, or when the active key is let go while the opposite
            // one is still down; both restart the DAS delay.
            if (oth_press_w || (!act_held_w && oth_held_w)) begin
              dir_q       <= ~dir_q;
              key_left_q  <= (dir_q != DIR_L);
              key_right_q <= (dir_q == DIR_L);
              hstate_q    <= H_DAS;
`ifdef INPUT_AUTOREPEAT_EN
              hcnt_q      <= '0;
`endif
            end else if (!act_held_w) begin
              hstate_q <= H_IDLE;
`ifdef INPUT_AUTOREPEAT_EN
              hcnt_q   <= '0;
            end else if (tick) begin
              // DAS and REPEAT share the counter; only the limit differs.
              if (hcnt_inc_w == hlimit_w) begin
                key_left_q  <= (dir_q == DIR_L);
                key_right_q <= (dir_q != DIR_L);
                hcnt_q      <= '0;
                hstate_q    <= H_REPEAT;
              end else begin
                hcnt_q <= hcnt_inc_w;
              end
`endif
            end
          end
        endcase
      end
    end
  end

  assign key_left      = key_left_q;
  assign key_right     = key_right_q;
  assign key_down      = key_down_q;
  assign key_rotate    = key_rotate_q;
  assign key_drop      = key_drop_q;
  assign key_hold      = key_hold_q;
  assign key_drop_held = key_drop_held_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for key_input_ctrl (DAS_TICKS=4, ARR_TICKS=2, SOFT_TICKS=2).
// Output vector bit order: {drop_held, hold, drop, rotate, down, right, left}.
// Works for both builds of INPUT_AUTOREPEAT_EN.
// ---------------------------------------------------------------------------
module tb_key_input_ctrl;

  localparam int DAS  = 4;
  localparam int ARR  = 2;
  localparam int SOFT = 2;
`ifdef INPUT_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b1;
  logic [5:0] held = 6'b0;  // {hold, drop, rotate, down, right, left}

  logic key_left, key_right, key_down, key_rotate, key_drop, key_hold, key_drop_held;
  logic [6:0] outs;
  assign outs = {key_drop_held, key_hold, key_drop, key_rotate, key_down, key_right, key_left};

  key_input_ctrl #(
    .DAS_TICKS (DAS),
    .ARR_TICKS (ARR),
    .SOFT_TICKS(SOFT),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .enable       (enable),
    .held_left    (held[0]),
    .held_right   (held[1]),
    .held_down    (held[2]),
    .held_rotate  (held[3]),
    .held_drop    (held[4]),
    .held_hold    (held[5]),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_down     (key_down),
    .key_rotate   (key_rotate),
    .key_drop     (key_drop),
    .key_hold     (key_hold),
    .key_drop_held(key_drop_held)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: tracks which direction is active and how many ticks
  // have elapsed since it became active, and ticks since down was pressed.
  bit [5:0] m_prev  = '0;
  bit       m_armed = 1'b0;
  int       m_active = 0;  // 0 none, 1 left, 2 right
  int       m_ht = 0;
  int       m_dt = 0;

  task automatic model_step(output logic [6:0] e);
    logic [5:0] pr;
    int oth;
    e = '0;
    if (rst) begin
      m_prev = '0; m_armed = 1'b0; m_active = 0; m_ht = 0; m_dt = 0;
      return;
    end
    pr = held & ~m_prev & {6{m_armed}};
    if (enable) begin
      e[3] = pr[3];
      e[4] = pr[4];
      e[5] = pr[5];
      e[6] = held[4];
      if (pr[2]) begin
        e[2] = 1'b1; m_dt = 0;
      end else if (held[2]) begin
        if (tick && AR) begin
          m_dt++;
          if (m_dt % SOFT == 0) e[2] = 1'b1;
        end
      end else begin
        m_dt = 0;
      end
      if (m_active == 0) begin
        if (pr[0]) begin m_active = 1; e[0] = 1'b1; m_ht = 0; end
        else if (pr[1]) begin m_active = 2; e[1] = 1'b1; m_ht = 0; end
      end else begin
        oth = 3 - m_active;
        if (pr[oth-1]) begin
          m_active = oth; e[oth-1] = 1'b1; m_ht = 0;
        end else if (!held[m_active-1]) begin
          if (held[oth-1]) begin m_active = oth; e[oth-1] = 1'b1; m_ht = 0; end
          else begin m_active = 0; m_ht = 0; end
        end else if (tick && AR) begin
          m_ht++;
          if (m_ht == DAS || (m_ht > DAS && (m_ht - DAS) % ARR == 0)) e[m_active-1] = 1'b1;
        end
      end
    end else begin
      m_active = 0; m_ht = 0; m_dt = 0;
    end
    m_prev  = held;
    m_armed = 1'b1;
  endtask

  task automatic check_vec(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Apply the current inputs for one clock, leaving the outputs in got and
  // the model's prediction in exp.
  task automatic step(output logic [6:0] got, output logic [6:0] exp);
    model_step(exp);
    @(posedge clk);
    #1;
    got = outs;
  endtask

  task automatic cyc(input string name);
    logic [6:0] g, e;
    step(g, e);
    check_vec(name, g, e);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       tick;
    logic [5:0] held;
    logic [6:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic en, input logic [5:0] h,
                              input logic [6:0] x);
    vec_t v;
    v.rst = r; v.en = en; v.tick = 1'b0; v.held = h; v.exp = x;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    logic [6:0] g, e;
    int cnt_l, cnt_r, cnt_d, cnt_any, cnt_dh;

    // Tick-free directed table: identical expectations in both builds.
    vecs[0]  = mk(1, 1, 6'b001000, 7'b0000000);  // reset with rotate held
    vecs[1]  = mk(1, 1, 6'b001000, 7'b0000000);
    vecs[2]  = mk(0, 1, 6'b001000, 7'b0000000);  // first post-reset cycle
    vecs[3]  = mk(0, 1, 6'b001000, 7'b0000000);
    vecs[4]  = mk(0, 1, 6'b001000, 7'b0000000);
    vecs[5]  = mk(0, 1, 6'b000000, 7'b0000000);  // release rotate
    vecs[6]  = mk(0, 1, 6'b001000, 7'b0001000);  // re-press -> key_rotate
    vecs[7]  = mk(0, 1, 6'b001000, 7'b0000000);
    vecs[8]  = mk(0, 1, 6'b000000, 7'b0000000);
    vecs[9]  = mk(0, 1, 6'b000011, 7'b0000001);  // L+R together -> left
    vecs[10] = mk(0, 1, 6'b000011, 7'b0000000);
    vecs[11] = mk(0, 1, 6'b010000, 7'b1010000);  // drop press + drop_held
    vecs[12] = mk(0, 1, 6'b010000, 7'b1000000);
    vecs[13] = mk(0, 0, 6'b010000, 7'b0000000);  // disabled
    vecs[14] = mk(0, 1, 6'b010000, 7'b1000000);  // held through enable
    vecs[15] = mk(0, 1, 6'b100000, 7'b0100000);  // hold press
    vecs[16] = mk(0, 1, 6'b000100, 7'b0000100);  // down press
    vecs[17] = mk(0, 1, 6'b000100, 7'b0000000);
    vecs[18] = mk(0, 1, 6'b000010, 7'b0000010);  // right press
    vecs[19] = mk(0, 1, 6'b000011, 7'b0000001);  // left press wins
    vecs[20] = mk(0, 1, 6'b000010, 7'b0000010);  // left released -> right
    vecs[21] = mk(0, 1, 6'b000000, 7'b0000000);

    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; enable = vecs[i].en; tick = vecs[i].tick; held = vecs[i].held;
      step(g, e);
      check_vec($sformatf("vec%0d", i), g, vecs[i].exp);
    end

    // Long left hold, tick every 10 cycles.
    cnt_l = 0; cnt_r = 0;
    for (int i = 0; i < 100; i++) begin
      held = 6'b000001; tick = (i % 10 == 9);
      step(g, e);
      check_vec("left_hold", g, e);
      cnt_l += g[0]; cnt_r += g[1];
    end
    check_int("left_hold_pulses", cnt_l, AR ? 5 : 1);
    check_int("left_hold_right", cnt_r, 0);
    held = 6'b0; tick = 1'b0;
    cyc("left_release");

    // Right held; left pressed on the 2nd tick; left later released.
    for (int i = 0; i < 80; i++) begin
      tick = (i % 10 == 9);
      held = (i >= 19 && i < 45) ? 6'b000011 : 6'b000010;
      step(g, e);
      check_vec("lpw_seq", g, e);
      if (i == 0)  check_vec("lpw_right_press", g[1:0], 7'b10);
      if (i == 19) check_vec("lpw_left_on_tick", g[1:0], 7'b01);
      if (i == 45) check_vec("lpw_release_switch", g[1:0], 7'b10);
    end
    held = 6'b0; tick = 1'b0;
    cyc("lpw_release");

    // Soft drop: 6 ticks of held down.
    cnt_d = 0;
    for (int i = 0; i < 30; i++) begin
      held = 6'b000100; tick = (i % 5 == 4);
      step(g, e);
      check_vec("soft_seq", g, e);
      cnt_d += g[2];
    end
    check_int("soft_pulses", cnt_d, AR ? 4 : 1);
    held = 6'b0; tick = 1'b0;
    cyc("soft_release");

    // Enable gating during REPEAT, with drop held.
    for (int i = 0; i < 60; i++) begin
      held = 6'b010001; tick = (i % 5 == 4);
      cyc("en_pre");
    end
    cnt_any = 0; cnt_dh = 0;
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 5 == 4);
      step(g, e);
      check_vec("en_off", g, e);
      cnt_any += g[0] + g[1]; cnt_dh += g[6];
    end
    check_int("en_off_pulses", cnt_any, 0);
    check_int("en_off_drop_held", cnt_dh, 0);
    enable = 1'b1; held = 6'b000001; cnt_any = 0;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 5 == 4);
      step(g, e);
      check_vec("en_back", g, e);
      cnt_any += g[0] + g[1];
    end
    check_int("en_back_pulses", cnt_any, 0);
    held = 6'b0; tick = 1'b0;
    cyc("en_release");
    held = 6'b000001;
    step(g, e);
    check_vec("en_repress", g[1:0], 7'b01);
    held = 6'b0;
    cyc("en_release2");

    // Reset while left is held in DAS.
    held = 6'b000001;
    for (int i = 0; i < 4; i++) cyc("rst_mid_pre");
    rst = 1'b1;
    cyc("rst_mid_a");
    cyc("rst_mid_b");
    rst = 1'b0; cnt_l = 0;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 3 == 2);
      step(g, e);
      check_vec("rst_mid_hold", g, e);
      cnt_l += g[0];
    end
    check_int("rst_mid_no_pulse", cnt_l, 0);
    held = 6'b0; tick = 1'b0;
    cyc("rst_mid_release");

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 6; b++)
        if ($urandom_range(7) == 0) held[b] = ~held[b];
      tick   = ($urandom_range(2) == 0);
      enable = ($urandom_range(24) != 0);
      rst    = ($urandom_range(299) == 0);
      step(g, e);
      check_vec("random", g, e);
      if (g[0] && g[1]) check_int("random_lr_exclusive", 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
